// File: rtl/reg_to_apb.sv
// ----------------------------------------------------------------------------
// reg_to_apb
//   Bridges a register-interface request/response port to a single APB4
//   completer. Every accepted register request becomes one APB SETUP/ACCESS
//   transfer. An optional timeout ends an ACCESS phase that the completer
//   never acknowledges, and returns an error response.
//
// Ports
//   clk_i      in   clock, all logic on the rising edge
//   rst_ni     in   synchronous active-low reset
//   reg_req_i  in   register request {addr, write, wdata, wstrb, valid}
//   reg_rsp_o  out  register response {rdata, error, ready}
//   psel_o     out  APB select
//   penable_o  out  APB enable (ACCESS phase)
//   pwrite_o   out  APB direction, 1 = write
//   paddr_o    out  APB address (captured request address)
//   pwdata_o   out  APB write data
//   pstrb_o    out  APB write strobes, all zero on reads
//   pprot_o    out  constant PPROT
//   prdata_i   in   APB read data
//   pready_i   in   APB ready
//   pslverr_i  in   APB error
// ----------------------------------------------------------------------------
module reg_to_apb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [2:0]  PPROT          = 3'b000,
    parameter type reg_req_t = struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    write;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wstrb;
        logic                    valid;
    },
    parameter type reg_rsp_t = struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  error;
        logic                  ready;
    }
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  reg_req_t                reg_req_i,
    output reg_rsp_t                reg_rsp_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    output logic [2:0]              pprot_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // The counter only has to reach TIMEOUT_CYCLES-1; wider is pointless.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path through the case statement leaves it unassigned (no latch).
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d  = reg_req_i.addr;
                    write_d = reg_req_i.write;
                    wdata_d = reg_req_i.wdata;
                    // Masking at capture keeps pstrb_o a plain register.
                    wstrb_d = reg_req_i.write ? reg_req_i.wstrb : '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rdata_d = write_q ? '0 : prdata_i;
                    error_d = pslverr_i;
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // Upstream valid is still high here; re-accepting would
                // duplicate the request, so always pass through IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch
        // and clk_i alone appears in the sensitivity list.
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its _d signal, independent of order.
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // All outputs are registers or state decodes; no APB input reaches them
    // combinationally.
    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pstrb_o   = wstrb_q;
    assign pprot_o   = PPROT;

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = (state_q == RESP);
    end

endmodule

// File: tb/tb_reg_to_apb.sv
// ----------------------------------------------------------------------------
// tb_reg_to_apb
//   Self-checking bench for reg_to_apb (TIMEOUT_CYCLES = 8). Each transfer is
//   described by its request, the number of wait cycles the completer inserts
//   and its response; the expected waveform (ACCESS length, response data and
//   error) is derived from those with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_reg_to_apb;

    localparam int         AW = 32;
    localparam int         DW = 32;
    localparam int         TO = 8;
    localparam logic [2:0] PP = 3'b010;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            write;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
        logic            valid;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
        logic          ready;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    req_t            req;
    rsp_t            rsp;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    int n_cmp = 0;
    int n_err = 0;

    reg_to_apb #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .PPROT         (PP),
        .reg_req_t     (req_t),
        .reg_rsp_t     (rsp_t)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .reg_req_i(req),
        .reg_rsp_o(rsp),
        .psel_o   (psel),
        .penable_o(penable),
        .pwrite_o (pwrite),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pstrb_o  (pstrb),
        .pprot_o  (pprot),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic s, input logic e, input logic r);
        check({tag, ".psel"},    64'(psel),      64'(s));
        check({tag, ".penable"}, 64'(penable),   64'(e));
        check({tag, ".ready"},   64'(rsp.ready), 64'(r));
    endtask

    // One complete transfer. Called at a falling edge with the DUT in IDLE,
    // returns at the falling edge where the DUT is back in IDLE.
    // w = wait cycles before pready; w >= TO means the completer never answers.
    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                           input int w, input logic err, input logic [DW-1:0] prd,
                           input logic hold);
        logic            to;
        int              acc_len;
        logic [DW-1:0]   exp_rd;
        logic            exp_err;
        logic [DW/8-1:0] exp_strb;

        to       = (TO != 0) && (w >= TO);
        acc_len  = to ? TO : w + 1;
        exp_rd   = (wr || to) ? '0 : prd;
        exp_err  = to ? 1'b1 : err;
        exp_strb = wr ? strb : '0;

        check_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = addr;
        req.wdata = wdata;
        req.wstrb = strb;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);

        @(negedge clk);
        check_ctrl({tag, ".setup"}, 1'b1, 1'b0, 1'b0);
        check({tag, ".paddr"},  64'(paddr),  64'(addr));
        check({tag, ".pwrite"}, 64'(pwrite), 64'(wr));
        check({tag, ".pwdata"}, 64'(pwdata), 64'(wdata));
        check({tag, ".pstrb"},  64'(pstrb),  64'(exp_strb));
        check({tag, ".pprot"},  64'(pprot),  64'(PP));
        // Disturb the request; the APB side must keep the captured values.
        req.addr  = $urandom;
        req.wdata = $urandom;
        req.wstrb = 4'($urandom);
        req.write = 1'($urandom);

        for (int i = 0; i < acc_len; i++) begin
            @(negedge clk);
            check_ctrl({tag, ".access"}, 1'b1, 1'b1, 1'b0);
            check({tag, ".acc_paddr"},  64'(paddr),  64'(addr));
            check({tag, ".acc_pwdata"}, 64'(pwdata), 64'(wdata));
            check({tag, ".acc_pstrb"},  64'(pstrb),  64'(exp_strb));
            check({tag, ".acc_pwrite"}, 64'(pwrite), 64'(wr));
            pready  = (i == w);
            pslverr = (i == w) ? err : 1'($urandom);
            prdata  = (i == w) ? prd : DW'($urandom);
        end

        @(negedge clk);
        check_ctrl({tag, ".resp"}, 1'b0, 1'b0, 1'b1);
        check({tag, ".rdata"}, 64'(rsp.rdata), 64'(exp_rd));
        check({tag, ".error"}, 64'(rsp.error), 64'(exp_err));
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = DW'($urandom);
        if (!hold) req.valid = 1'b0;

        @(negedge clk);
        check_ctrl({tag, ".after"}, 1'b0, 1'b0, 1'b0);
        check({tag, ".rdata_hold"}, 64'(rsp.rdata), 64'(exp_rd));
        check({tag, ".error_hold"}, 64'(rsp.error), 64'(exp_err));
    endtask

    initial begin
        logic            r_wr;
        logic [DW/8-1:0] r_strb;
        int              r_w;
        logic            r_hold;

        req     = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check("reset.rdata",  64'(rsp.rdata), 64'd0);
        check("reset.error",  64'(rsp.error), 64'd0);
        check("reset.paddr",  64'(paddr),     64'd0);
        check("reset.pwdata", 64'(pwdata),    64'd0);
        check("reset.pstrb",  64'(pstrb),     64'd0);
        check("reset.pwrite", 64'(pwrite),    64'd0);
        check("reset.pprot",  64'(pprot),     64'(PP));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_txn("rd_basic", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        run_txn("wr_wait3", 1'b1, 32'h20, 32'h12345678, 4'b0101, 3, 1'b0, 32'h55AA55AA, 1'b0);
        run_txn("rd_slverr", 1'b0, 32'h30, 32'h0, 4'hF, 1, 1'b1, 32'hCAFEF00D, 1'b0);
        run_txn("rd_timeout", 1'b0, 32'h40, 32'h0, 4'h0, 20, 1'b0, 32'h11111111, 1'b0);
        run_txn("rd_last_wait", 1'b0, 32'h44, 32'h0, 4'h0, TO - 1, 1'b0, 32'h76543210, 1'b0);
        run_txn("wr_timeout", 1'b1, 32'h48, 32'hA5A5A5A5, 4'hC, TO, 1'b0, 32'h0, 1'b0);
        run_txn("b2b_first", 1'b0, 32'h50, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 1'b1);
        run_txn("b2b_second", 1'b0, 32'h54, 32'h0, 4'h0, 0, 1'b0, 32'hFEEDFACE, 1'b0);

        // Reset in the middle of ACCESS
        req.valid = 1'b1;
        req.write = 1'b0;
        req.addr  = 32'h60;
        pready    = 1'b0;
        @(negedge clk);             // SETUP
        @(negedge clk);             // ACCESS, first cycle
        @(negedge clk);             // ACCESS, second cycle
        check_ctrl("mid_rst.pre", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_ctrl("mid_rst", 1'b0, 1'b0, 1'b0);
        check("mid_rst.rdata", 64'(rsp.rdata), 64'd0);
        check("mid_rst.paddr", 64'(paddr),     64'd0);
        rst_n     = 1'b1;
        req.valid = 1'b0;
        @(negedge clk);
        run_txn("post_rst", 1'b0, 32'h64, 32'h0, 4'h0, 2, 1'b0, 32'h13579BDF, 1'b0);

        // Random transfers
        for (int n = 0; n < 30; n++) begin
            r_wr   = 1'($urandom);
            r_strb = 4'($urandom);
            r_w    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12))
                                                 : int'($urandom_range(0, 2));
            r_hold = (n != 29) ? 1'($urandom) : 1'b0;
            run_txn($sformatf("rand%0d", n), r_wr, $urandom, $urandom, r_strb, r_w,
                    1'($urandom), $urandom, r_hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
